// File: rtl/blowfish128_pkg.sv
// Shared constants, FSM encoding and the F32 combine for the Blowfish128 data path.
package blowfish128_pkg;

  localparam int NROUNDS  = 8;
  localparam int BLK_W    = 128;
  localparam int HALF_W   = 64;
  localparam int SUBKEY_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RA   = 3'd1,
    RW   = 3'd2,
    RB   = 3'd3,
    FIN  = 3'd4,
    DONE = 3'd5
  } state_e;

  // ((S0 + S1) ^ S2) + S3, all additions mod 2^32.
  function automatic logic [SUBKEY_W-1:0] f32_combine(
    input logic [SUBKEY_W-1:0] s0,
    input logic [SUBKEY_W-1:0] s1,
    input logic [SUBKEY_W-1:0] s2,
    input logic [SUBKEY_W-1:0] s3
  );
    return ((s0 + s1) ^ s2) + s3;
  endfunction

endpackage

// File: rtl/blowfish128_f.sv
// Combinational F for one 64-bit half: two F32 combines over eight S-box lookup words.
module blowfish128_f
  import blowfish128_pkg::*;
(
  input  logic [4*HALF_W-1:0] sbox_dat_i,
  output logic [HALF_W-1:0]   f_o
);

  // Word 0 sits in the MSBs; words 0..3 form the upper F32, 4..7 the lower.
  assign f_o = {
    f32_combine(sbox_dat_i[255:224], sbox_dat_i[223:192],
                sbox_dat_i[191:160], sbox_dat_i[159:128]),
    f32_combine(sbox_dat_i[127:96],  sbox_dat_i[95:64],
                sbox_dat_i[63:32],   sbox_dat_i[31:0])
  };

endmodule

// File: rtl/blowfish128_core.sv
// Iterative 8-round Blowfish128 engine fed by skeygen2 with external S-box ROMs.
// Optional macro BF128_KEY_LATCH_EN: snapshot P1..P20 on the skey_ready rising edge.
module blowfish128_core
  import blowfish128_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  skey_ready,
  input  logic [SUBKEY_W-1:0]   P1,  P2,  P3,  P4,  P5,
  input  logic [SUBKEY_W-1:0]   P6,  P7,  P8,  P9,  P10,
  input  logic [SUBKEY_W-1:0]   P11, P12, P13, P14, P15,
  input  logic [SUBKEY_W-1:0]   P16, P17, P18, P19, P20,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLK_W-1:0]      in_block,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_W-1:0]      out_block,
  output logic [HALF_W-1:0]     sbox_idx,
  input  logic [4*HALF_W-1:0]   sbox_dat,
  output logic                  busy,
  output logic                  abort
);

  localparam logic [1:0] WAIT_LAST = (SBOX_LAT > 1) ? 2'(SBOX_LAT - 2) : 2'd0;
  localparam logic [3:0] LAST_RND  = 4'(NROUNDS);

  // K_i occupies the i-th 64-bit slot counting from the MSB end of {P1..P20}.
  function automatic logic [HALF_W-1:0] key_at(input logic [20*SUBKEY_W-1:0] k, input int i);
    return k[(10 - i) * HALF_W +: HALF_W];
  endfunction

  logic [20*SUBKEY_W-1:0] pk_live;
  logic [20*SUBKEY_W-1:0] pk;
  logic                   key_drop;

  assign pk_live = {P1, P2, P3, P4, P5, P6, P7, P8, P9, P10,
                    P11, P12, P13, P14, P15, P16, P17, P18, P19, P20};

`ifdef BF128_KEY_LATCH_EN
  logic [20*SUBKEY_W-1:0] pk_q;
  logic                   skey_prev_q;

  always_ff @(posedge Clk) begin
    if (Rst) skey_prev_q <= 1'b0;
    else     skey_prev_q <= skey_ready;
  end

  always_ff @(posedge Clk) begin
    if (skey_ready && !skey_prev_q) pk_q <= pk_live;
  end

  assign pk       = pk_q;
  assign key_drop = 1'b0;
`else
  assign pk       = pk_live;
  assign key_drop = !skey_ready;
`endif

  state_e              state_q;
  logic [3:0]          rnd_q;
  logic [1:0]          wcnt_q;
  logic [HALF_W-1:0]   l_q, r_q;
  logic [HALF_W-1:0]   idx_q;
  logic [BLK_W-1:0]    out_q;
  logic                out_valid_q;
  logic                abort_q;

  logic [HALF_W-1:0]   k_rnd, k9, k10, l_x, f_l;

  assign k_rnd = key_at(pk, int'(rnd_q));
  assign k9    = key_at(pk, 9);
  assign k10   = key_at(pk, 10);
  assign l_x   = l_q ^ k_rnd;

  blowfish128_f u_f (
    .sbox_dat_i (sbox_dat),
    .f_o        (f_l)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      wcnt_q      <= 2'd0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      // A live key vanishing mid-block invalidates it; DONE already holds a good result.
      if (key_drop && (state_q inside {RA, RW, RB, FIN})) begin
        state_q <= IDLE;
        abort_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid && skey_ready) begin
              l_q     <= in_block[BLK_W-1:HALF_W];
              r_q     <= in_block[HALF_W-1:0];
              rnd_q   <= 4'd1;
              state_q <= RA;
            end
          end
          RA: begin
            l_q     <= l_x;
            idx_q   <= l_x;
            wcnt_q  <= 2'd0;
            state_q <= (SBOX_LAT > 1) ? RW : RB;
          end
          RW: begin
            if (wcnt_q == WAIT_LAST) state_q <= RB;
            else                     wcnt_q  <= wcnt_q + 2'd1;
          end
          RB: begin
            l_q <= r_q ^ f_l;
            r_q <= l_q;
            if (rnd_q < LAST_RND) begin
              rnd_q   <= rnd_q + 4'd1;
              state_q <= RA;
            end else begin
              state_q <= FIN;
            end
          end
          FIN: begin
            // Undo the final swap, then whiten: R ^= K9, L ^= K10.
            out_q       <= {r_q ^ k10, l_q ^ k9};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
          DONE: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && skey_ready && !Rst;
  assign out_valid = out_valid_q;
  assign out_block = out_q;
  assign sbox_idx  = idx_q;
  assign busy      = (state_q != IDLE);
  assign abort     = abort_q;

endmodule

// File: tb/tb_blowfish128_core.sv
// Self-checking bench for blowfish128_core: SBOX_LAT=1 and SBOX_LAT=3 instances, table vectors plus corner sequences.
module tb_blowfish128_core;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         skey_ready;
  logic [639:0] pcur;
  logic [31:0]  pw [1:20];
  logic         in_valid, in_valid3;
  logic [127:0] in_block;
  logic         out_ready, out_ready3;
  logic         in_ready, in_ready3, out_valid, out_valid3;
  logic [127:0] out_block, out_block3;
  logic [63:0]  idx1, idx3, idx3_d1, idx3_d2;
  logic [255:0] dat1, dat3;
  logic         busy, busy3, abort, abort3;
  bit           zs;

  int nchk = 0;
  int nerr = 0;
  logic [127:0] sb_q [$];

  always #5 Clk = ~Clk;

  for (genvar g = 1; g <= 20; g++) begin : g_pw
    assign pw[g] = pcur[(20 - g) * 32 +: 32];
  end

  blowfish128_core #(.SBOX_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst), .skey_ready(skey_ready),
    .P1(pw[1]),   .P2(pw[2]),   .P3(pw[3]),   .P4(pw[4]),   .P5(pw[5]),
    .P6(pw[6]),   .P7(pw[7]),   .P8(pw[8]),   .P9(pw[9]),   .P10(pw[10]),
    .P11(pw[11]), .P12(pw[12]), .P13(pw[13]), .P14(pw[14]), .P15(pw[15]),
    .P16(pw[16]), .P17(pw[17]), .P18(pw[18]), .P19(pw[19]), .P20(pw[20]),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .sbox_idx(idx1), .sbox_dat(dat1), .busy(busy), .abort(abort)
  );

  blowfish128_core #(.SBOX_LAT(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .skey_ready(skey_ready),
    .P1(pw[1]),   .P2(pw[2]),   .P3(pw[3]),   .P4(pw[4]),   .P5(pw[5]),
    .P6(pw[6]),   .P7(pw[7]),   .P8(pw[8]),   .P9(pw[9]),   .P10(pw[10]),
    .P11(pw[11]), .P12(pw[12]), .P13(pw[13]), .P14(pw[14]), .P15(pw[15]),
    .P16(pw[16]), .P17(pw[17]), .P18(pw[18]), .P19(pw[19]), .P20(pw[20]),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_block(in_block),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_block(out_block3),
    .sbox_idx(idx3), .sbox_dat(dat3), .busy(busy3), .abort(abort3)
  );

  // Pseudo-random S-box contents; all zero when z is set.
  function automatic logic [31:0] sb(input int j, input logic [7:0] b, input bit z);
    logic [31:0] x;
    if (z) return 32'h0;
    x = {b, b ^ 8'h5A, ~b, b + 8'(j)};
    x = x * 32'h2545F491 + 32'(j) * 32'h6C8E9CF5;
    return x ^ (x >> 13);
  endfunction

  function automatic logic [255:0] rom(input logic [63:0] idx, input bit z);
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[255 - 32*j -: 32] = sb(j % 4, idx[63 - 8*j -: 8], z);
    return d;
  endfunction

  // Sync ROM: LAT-1 extra register stages after the core's registered index.
  always_ff @(posedge Clk) begin
    idx3_d1 <= idx3;
    idx3_d2 <= idx3_d1;
  end
  always_comb dat1 = rom(idx1, zs);
  always_comb dat3 = rom(idx3_d2, zs);

  function automatic logic [31:0] f32r(input logic [31:0] w, input bit z);
    return ((sb(0, w[31:24], z) + sb(1, w[23:16], z)) ^ sb(2, w[15:8], z)) + sb(3, w[7:0], z);
  endfunction

  function automatic logic [63:0] kof(input logic [639:0] pk, input int i);
    return {pk[(20 - (2*i - 1)) * 32 +: 32], pk[(20 - 2*i) * 32 +: 32]};
  endfunction

  // Reference Blowfish128 block function, C-style loop.
  function automatic logic [127:0] bf_ref(input logic [639:0] pk, input logic [127:0] pt, input bit z);
    logic [63:0] l, r, t;
    l = pt[127:64];
    r = pt[63:0];
    for (int i = 1; i <= 8; i++) begin
      l = l ^ kof(pk, i);
      r = r ^ {f32r(l[63:32], z), f32r(l[31:0], z)};
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ kof(pk, 9);
    l = l ^ kof(pk, 10);
    return {l, r};
  endfunction

  logic [639:0] keyZ, keyB, keyBd;

  function automatic logic [639:0] ksel(input int s);
    return (s == 0) ? keyZ : (s == 1) ? keyB : keyBd;
  endfunction

  typedef struct {
    logic [127:0] pt;
    int           kset;
    bit           z;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_keys(input logic [639:0] k);
    skey_ready = 1'b0;
    tick();
    pcur = k;
    skey_ready = 1'b1;
    tick();
  endtask

  task automatic start(input bit sel, input logic [127:0] pt, output bit ok);
    int n = 0;
    while (!(sel ? in_ready3 : in_ready) && n < 30) begin tick(); n++; end
    ok = sel ? in_ready3 : in_ready;
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL accept_timeout: in_ready never rose");
      return;
    end
    in_block = pt;
    if (sel) in_valid3 = 1'b1; else in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_valid3 = 1'b0;
  endtask

  task automatic wait_out(input bit sel, output int n);
    n = 0;
    do begin tick(); n++; end while (!(sel ? out_valid3 : out_valid) && n < 80);
    if (!(sel ? out_valid3 : out_valid)) begin
      nchk++; nerr++;
      $display("FAIL out_timeout: out_valid never rose");
      n = -1;
    end
  endtask

  task automatic run_blk(input bit sel, input logic [127:0] pt, input logic [127:0] exp,
                         input int exp_lat, input string nm);
    bit ok;
    int n;
    logic [127:0] e;
    start(sel, pt, ok);
    if (!ok) return;
    sb_q.push_back(exp);
    wait_out(sel, n);
    e = sb_q.pop_front();
    if (n < 0) return;
    chk({nm, "_lat"}, 128'(n), 128'(exp_lat));
    chk(nm, sel ? out_block3 : out_block, e);
    tick();
    chk({nm, "_hs"}, 128'(sel ? out_valid3 : out_valid), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]  kw [4];
    logic [31:0]  w;
    logic [127:0] pt1, pt2, ct1, ct2, e;
    bit           ok;
    int           n, abort_cnt, abort_at, ov_at;
    logic [127:0] got_blk;

    Rst = 1'b1; skey_ready = 1'b0; pcur = '0; zs = 1'b1;
    in_valid = 1'b0; in_valid3 = 1'b0; in_block = '0;
    out_ready = 1'b1; out_ready3 = 1'b1;

    // Stand-in for skeygen2's P-array, derived from the test key words.
    kw[0] = 64'h0123456789ABCDEF; kw[1] = 64'h2233445566778899;
    kw[2] = 64'h445566778899AABB; kw[3] = 64'h99AABBCCDDEEFF00;
    keyZ = {32'h01234567, 32'h89ABCDEF, 576'h0};
    for (int j = 1; j <= 20; j++) begin
      w = (j % 2) ? kw[(j - 1) % 4][63:32] : kw[(j - 1) % 4][31:0];
      keyB[(20 - j) * 32 +: 32] = w ^ (32'(j) * 32'h9E3779B9);
    end
    for (int i = 1; i <= 10; i++) keyBd[(10 - i) * 64 +: 64] = kof(keyB, 11 - i);

    pt1 = 128'h00112233445566778899AABBCCDDEEFF;
    pt2 = 128'hDEADBEEF0BADF00DCAFEBABE13579BDF;
    ct1 = bf_ref(keyB, pt1, 1'b0);
    ct2 = bf_ref(keyB, pt2, 1'b0);
    vecs[0] = '{pt: 128'h0, kset: 0, z: 1'b1, exp: {64'h0, 64'h0123456789ABCDEF}};
    vecs[1] = '{pt: pt1, kset: 1, z: 1'b0, exp: ct1};
    vecs[2] = '{pt: ct1, kset: 2, z: 1'b0, exp: pt1};
    vecs[3] = '{pt: pt2, kset: 1, z: 1'b0, exp: ct2};
    vecs[4] = '{pt: ct2, kset: 2, z: 1'b0, exp: pt2};

    tick(); tick();
    chk("rst_in_ready",  128'(in_ready),  128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_block", out_block,       128'd0);
    chk("rst_sbox_idx",  128'(idx1),      128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_abort",     128'(abort),     128'd0);
    Rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      zs = vecs[i].z;
      set_keys(ksel(vecs[i].kset));
      run_blk(1'b0, vecs[i].pt, vecs[i].exp, 17, $sformatf("vec%0d", i));
    end
    chk("roundtrip_ct1", bf_ref(keyBd, ct1, 1'b0), pt1);

    // Consumer stalls for ten cycles in DONE.
    zs = 1'b0;
    set_keys(keyB);
    out_ready = 1'b0;
    start(1'b0, pt1, ok);
    if (ok) begin
      sb_q.push_back(ct1);
      wait_out(1'b0, n);
      e = sb_q.pop_front();
      chk("hold_lat", 128'(n), 128'd17);
      chk("hold_blk", out_block, e);
      for (int k = 0; k < 10; k++) begin
        tick();
        chk($sformatf("hold_valid%0d", k), 128'(out_valid), 128'd1);
        chk($sformatf("hold_stable%0d", k), out_block, e);
        chk($sformatf("hold_inrdy%0d", k), 128'(in_ready), 128'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("hold_release", 128'(out_valid), 128'd0);
    end
    out_ready = 1'b1;

    // Reset landing in RB of round 4.
    start(1'b0, pt2, ok);
    if (ok) begin
      for (int k = 0; k < 7; k++) tick();
      chk("mid_busy", 128'(busy), 128'd1);
      Rst = 1'b1;
      tick();
      chk("mid_rst_busy",      128'(busy),      128'd0);
      chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
      chk("mid_rst_out_block", out_block,       128'd0);
      chk("mid_rst_sbox_idx",  128'(idx1),      128'd0);
      chk("mid_rst_abort",     128'(abort),     128'd0);
      chk("mid_rst_in_ready",  128'(in_ready),  128'd0);
      Rst = 1'b0;
      tick();
    end
    run_blk(1'b0, pt2, ct2, 17, "after_rst");

    // skey_ready drops in RA of round 3, with the P words corrupted meanwhile.
    start(1'b0, pt1, ok);
    if (ok) begin
`ifdef BF128_KEY_LATCH_EN
      sb_q.push_back(ct1);
`endif
      abort_cnt = 0; abort_at = 0; ov_at = 0; got_blk = '0;
      for (int k = 1; k <= 40; k++) begin
        if (k == 5) begin skey_ready = 1'b0; pcur = '0; end
        tick();
        if (abort) begin abort_cnt++; abort_at = k; end
        if (out_valid && ov_at == 0) begin ov_at = k; got_blk = out_block; end
      end
`ifdef BF128_KEY_LATCH_EN
      e = sb_q.pop_front();
      chk("drop_abort_cnt", 128'(abort_cnt), 128'd0);
      chk("drop_lat",       128'(ov_at),     128'd17);
      chk("drop_blk",       got_blk,         e);
`else
      chk("drop_abort_cnt", 128'(abort_cnt), 128'd1);
      chk("drop_abort_at",  128'(abort_at),  128'd5);
      chk("drop_no_out",    128'(ov_at),     128'd0);
`endif
    end
    in_valid = 1'b1;
    in_block = pt1;
    tick(); tick(); tick();
    chk("nokey_busy",     128'(busy),     128'd0);
    chk("nokey_in_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0;

    // Three-cycle ROM: same ciphertext, longer latency.
    set_keys(keyB);
    run_blk(1'b1, pt1, ct1, 33, "lat3");
    run_blk(1'b0, pt1, ct1, 17, "lat1_ref");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
